// File: rtl/seg7_scan_if.sv
// seg7_scan_if: digit-in / segment-out bundle for seg7_scan_driver.
//   sel      slot select (same source as the accumulator's select)
//   digit_in accumulator output, lags sel by one cycle
//   seg      segments {g,f,e,d,c,b,a}, active-low
//   an       digit anodes, active-low, an[0] = slot 0
// master: the accumulator/display side that drives sel/digit_in.
// slave:  the scan driver.
interface seg7_scan_if;
  logic       sel;
  logic [3:0] digit_in;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (output sel, digit_in, input  seg, an);
  modport slave  (input  sel, digit_in, output seg, an);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: two-digit multiplexed common-anode 7-segment driver.
// Shadows the accumulator's two slots (digit_in lags sel by one cycle, so
// captures are steered by the registered select), scans both digits with
// one dead-time cycle per slot, and decodes hex to active-low segments.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_if.slave (sel, digit_in in; seg, an out, registered)
//
// Parameters:
//   REFRESH_DIV  cycles per digit slot including the dead cycle (>= 2)
//   BLINK_DIV    scan periods per blink half-phase (>= 1), blink build only
//
// Build option: define DISP_BLINK_EN to blank the currently selected digit
// on alternate blink half-phases. Without it both digits are always lit.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  seg7_scan_if.slave bus
);

  localparam int              CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]   cnt;
  logic            idx;
  logic            sel_q;
  logic [1:0][3:0] slot;
  logic            phase;
  logic            dead;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_q, an_d;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'h40;
      4'd1:    dec7 = 7'h79;
      4'd2:    dec7 = 7'h24;
      4'd3:    dec7 = 7'h30;
      4'd4:    dec7 = 7'h19;
      4'd5:    dec7 = 7'h12;
      4'd6:    dec7 = 7'h02;
      4'd7:    dec7 = 7'h78;
      4'd8:    dec7 = 7'h00;
      4'd9:    dec7 = 7'h10;
      default: dec7 = 7'h3F;  // out-of-range digit shows a dash
    endcase
  endfunction

  assign dead = (cnt == CNT_LAST);

  // Scan, slot shadow and output registers. digit_in belongs to the slot
  // selected one cycle earlier, hence the write index is sel_q, not sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= 1'b0;
      sel_q <= 1'b0;
      slot  <= '0;
      seg_q <= 7'h7F;
      an_q  <= 2'b11;
    end else begin
      sel_q       <= bus.sel;
      slot[sel_q] <= bus.digit_in;
      cnt         <= dead ? '0 : cnt + CW'(1);
      if (dead) idx <= ~idx;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt;

  // Advances once per full scan period (idx wrapping 1 -> 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (dead && idx) begin
      if (bcnt == BLINK_LAST) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt  <= bcnt + BW'(1);
      end
    end
  end
`else
  assign phase = 1'b0;
`endif

  // Next outputs from pre-edge state; dead cycle keeps both anodes off so
  // the segment change never ghosts onto the neighbouring digit.
  always_comb begin
    an_d  = dead ? 2'b11 : ~(2'b01 << idx);
    seg_d = (phase && (idx == sel_q)) ? 7'h7F : dec7(slot[idx]);
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV = 4, BLINK_DIV = 2.
// Vector table: each record is applied before a clock edge and the outputs
// are checked on the following falling edge. A record with rst set pulses
// reset first, so the next edge is edge 1 after release.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  seg7_scan_if bus ();

  seg7_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef DISP_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct {
    bit         rst;
    logic       sel;
    logic [3:0] din;
    logic [1:0] an;
    logic [6:0] seg;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input logic s, input logic [3:0] d,
                     input logic [1:0] a, input logic [6:0] g);
    vec_t v;
    v.rst = r; v.sel = s; v.din = d; v.an = a; v.seg = g;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.sel      = 1'b0;
    bus.digit_in = 4'd0;
    #1;
    chk("reset_an", {30'd0, bus.an}, 32'h3);
    chk("reset_seg", {25'd0, bus.seg}, 32'h7F);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic s, input logic [3:0] d);
    bus.sel      = s;
    bus.digit_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] dec_exp [16];
    logic [1:0] e_an;
    logic [6:0] e_seg;
    int         ph;

    bus.sel      = 1'b0;
    bus.digit_in = 4'd0;

    // Scenario 1: idle after reset, all zeros.
    add(1,0,0,2'b10,7'h40); add(0,0,0,2'b10,7'h40); add(0,0,0,2'b10,7'h40); add(0,0,0,2'b11,7'h40);
    add(0,0,0,2'b01,7'h40); add(0,0,0,2'b01,7'h40); add(0,0,0,2'b01,7'h40); add(0,0,0,2'b11,7'h40);
    // Scenario 2: sel=1 d=7 (lagged), then sel=0 d=3 (lagged).
    add(1,1,0,2'b10,7'h40); add(0,1,7,2'b10,7'h40); add(0,1,7,2'b10,7'h40); add(0,1,7,2'b11,7'h40);
    add(0,1,7,2'b01,7'h78); add(0,1,7,2'b01,7'h78); add(0,1,7,2'b01,7'h78); add(0,1,7,2'b11,7'h78);
    add(0,1,7,2'b10,7'h40); add(0,1,7,2'b10,7'h40); add(0,0,7,2'b10,7'h40); add(0,0,3,2'b11,7'h40);
    add(0,0,3,2'b01,7'h78); add(0,0,3,2'b01,7'h78); add(0,0,3,2'b01,7'h78); add(0,0,3,2'b11,7'h78);
    add(0,0,3,2'b10,7'h30); add(0,0,3,2'b10,7'h30); add(0,0,3,2'b10,7'h30); add(0,0,3,2'b11,7'h30);
    add(0,0,3,2'b01,7'h78); add(0,0,3,2'b01,7'h78); add(0,0,3,2'b01,7'h78); add(0,0,3,2'b11,7'h78);
    // Scenario 3: sel toggles every cycle, digit_in lags one cycle (5 / 9).
    add(1,0,5,2'b10,7'h40); add(0,1,5,2'b10,7'h12); add(0,0,9,2'b10,7'h12); add(0,1,5,2'b11,7'h12);
    add(0,0,9,2'b01,7'h10); add(0,1,5,2'b01,7'h10); add(0,0,9,2'b01,7'h10); add(0,1,5,2'b11,7'h10);
    add(0,0,9,2'b10,7'h12); add(0,1,5,2'b10,7'h12); add(0,0,9,2'b10,7'h12); add(0,1,5,2'b11,7'h12);
    // Scenario 4: out-of-range digit shows a dash.
    add(1,0,4'hC,2'b10,7'h40); add(0,0,4'hC,2'b10,7'h3F); add(0,0,4'hC,2'b10,7'h3F); add(0,0,4'hC,2'b11,7'h3F);

    dec_exp = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      step(vq[i].sel, vq[i].din);
      chk($sformatf("vec%0d_an", i), {30'd0, bus.an}, {30'd0, vq[i].an});
      chk($sformatf("vec%0d_seg", i), {25'd0, bus.seg}, {25'd0, vq[i].seg});
    end

    // Decode sweep: every digit value through slot 0, seen at edge 2.
    for (int v = 0; v < 16; v++) begin
      do_reset();
      step(1'b0, 4'(v));
      step(1'b0, 4'(v));
      chk($sformatf("decode%0d", v), {25'd0, bus.seg}, {25'd0, dec_exp[v]});
    end

    // Asynchronous reset mid-scan with idx = 1 and slot 1 = 8.
    do_reset();
    step(1'b1, 4'd0);
    for (int k = 2; k <= 6; k++) step(1'b1, 4'd8);
    chk("midscan_an", {30'd0, bus.an}, 32'h1);
    chk("midscan_seg", {25'd0, bus.seg}, 32'h00);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", {30'd0, bus.an}, 32'h3);
    chk("async_rst_seg", {25'd0, bus.seg}, 32'h7F);
    bus.sel      = 1'b0;
    bus.digit_in = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'd0);
    chk("post_rst_first_an", {30'd0, bus.an}, 32'h2);
    for (int k = 2; k <= 5; k++) step(1'b0, 4'd0);
    chk("post_rst_slot1_an", {30'd0, bus.an}, 32'h1);
    chk("post_rst_slot1_seg", {25'd0, bus.seg}, 32'h40);

    // Blink: sel = 1, slot 1 = 2; digit 1 blanks on odd 16-cycle windows
    // only in the blink build, digit 0 never blanks.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, (k == 1) ? 4'd0 : 4'd2);
      ph    = (k - 1) % 8;
      e_an  = (ph == 3 || ph == 7) ? 2'b11 : (ph < 3) ? 2'b10 : 2'b01;
      if (ph < 4)                                  e_seg = 7'h40;
      else if (BLINK && (((k - 1) / 16) % 2 == 1)) e_seg = 7'h7F;
      else                                         e_seg = 7'h24;
      chk($sformatf("blink%0d_an", k), {30'd0, bus.an}, {30'd0, e_an});
      chk($sformatf("blink%0d_seg", k), {25'd0, bus.seg}, {25'd0, e_seg});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
